uart_rx_axis: RTL
=================

# uart_rx_axis

UART receiver with a small byte FIFO, producing the 8-bit AXI-Stream that feeds the host command decoder in front of the ODIN core. It converts serial host traffic into bytes for the command decoder: synapse/neuron writes, AER events and configuration writes. Its output holds `tdata`/`tvalid` stable until accepted, so the decoder's one-cycle `tready` pulses each consume exactly one byte. Framing and overrun errors are reported as single-cycle pulses; bad bytes never reach the stream.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 8.
- `FIFO_DEPTH`, default 16: FIFO entries. Must be a power of 2, ≥ 2.
- `clk`  in  1  single system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `uart_rxd`  in  1  asynchronous serial line, idle high, 8N1, LSB first.
- `m_axis_tdata`  out  8  byte at FIFO head.
- `m_axis_tvalid`  out  1  FIFO not empty.
- `m_axis_tready`  in  1  consumer accepts head byte when high with `tvalid`.
- `frame_err`  out  1  one-cycle pulse when a stop bit is sampled low.
- `overrun`  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.

## Operation
- Synchronizer: two flops on `uart_rxd`, both reset to 1. All FSM decisions use the second flop, `rxd_s`.
- Counters:
  - Bit-timer `cnt`, wide enough for CLKS_PER_BIT-1.
  - Bit index `idx`, 3 bits.
  - Shift register `sh`, 8 bits, filled LSB first by shifting right.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: `cnt`=0. When `rxd_s`=0, go to START.
  - START: `cnt` increments. At `cnt`==CLKS_PER_BIT/2-1 (integer division), sample `rxd_s`:
    - 0: go to DATA with `cnt`=0, `idx`=0.
    - 1: false start, go to IDLE, no error.
  - DATA: at `cnt`==CLKS_PER_BIT-1, sample `rxd_s` into `sh[7]` with a right shift, and set `cnt`=0. After the sample with `idx`==7, go to STOP; otherwise `idx`++.
  - STOP: at `cnt`==CLKS_PER_BIT-1, sample `rxd_s`:
    - 1: push `sh` into the FIFO and go to IDLE. Returning mid-stop-bit allows resync on the next start edge.
    - 0: pulse `frame_err`, discard `sh`, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxd_s`=1, then go to IDLE. A break condition therefore produces exactly one `frame_err`.
- FIFO:
  - `rd_ptr`/`wr_ptr` wrap modulo FIFO_DEPTH; a separate count holds `fifo_level`.
  - `m_axis_tdata` = mem[`rd_ptr`], a combinational read. `m_axis_tvalid` = (level != 0).
  - Pop on `tvalid && tready`. `tready` with an empty FIFO has no effect.
  - Push request with level < FIFO_DEPTH: write, increment `wr_ptr`.
  - Push request at full with a simultaneous pop: accepted, level unchanged, no overrun.
  - Push request at full without a pop: byte dropped, `overrun` pulses, FIFO contents unchanged.
  - Simultaneous push and pop at any level: level unchanged. Head data stays valid until the pop.
- Reset (asynchronous, any time, including mid-frame):
  - FSM to IDLE; `cnt`, `idx`, `sh`, pointers and level to 0.
  - Stored bytes are lost.
  - Outputs: `m_axis_tvalid`=0, `m_axis_tdata`=mem[0] (don't-care, not reset), `frame_err`=0, `overrun`=0, `fifo_level`=0.
- `frame_err` and `overrun` are registered, high for exactly one cycle per event.

## Timing
- Let t0 be the first cycle `rxd_s`=0 in IDLE. This is 2–3 clk after the pin falls (synchronizer latency).
- START is entered at t0+1. H = t0 + CLKS_PER_BIT/2.
- Sample times:
  - Start-bit sample: H.
  - Data bit i (i=0..7) sample: H + (i+1)·CLKS_PER_BIT.
  - Stop sample: H + 9·CLKS_PER_BIT. The push occurs in this cycle.
- `m_axis_tvalid` rises and `fifo_level` updates the cycle after the push. `frame_err`/`overrun` assert the cycle after the stop sample.
- Pop: the pointer and level update on the edge where `tvalid && tready`. The next byte, if present, appears on `tdata` in the following cycle.
- Back-to-back frames: the FSM is in IDLE at H+9·CLKS_PER_BIT+1, which is ≤ CLKS_PER_BIT/2 cycles before the next start edge at nominal baud. Tolerance is ±4% baud mismatch.

## Test plan
Benches use CLKS_PER_BIT=16 and FIFO_DEPTH=4.
- Single byte: send 0x81 with nothing consuming. `tvalid` rises 1 cycle after the stop sample, `tdata`=0x81, level=1. Pulse `tready` for one cycle → `tvalid`=0, level=0.
- Decoder stream: send 0xA0 0x12 0x34 0x56 (synapse write) back-to-back, `tready` pulsing once per `tvalid` with a gap cycle between pulses → exactly 4 bytes accepted in order, no errors.
- Overrun: hold `tready`=0 and send 5 bytes 0x01..0x05 → level=4 and `overrun` pulses once at byte 5. Then drain → 0x01..0x04 delivered.
- Full plus simultaneous pop: level=4, raise `tready` in the stop-sample cycle of byte 0x05 → no `overrun`, level stays 4, drain yields 0x02..0x05.
- Framing and break:
  - Send 0x55 with stop bit 0 → one `frame_err`, level unchanged.
  - Hold the line low for 40 bit times → one `frame_err` only.
  - Release the line, then send 0x3C → 0x3C received correctly.
- Glitch and reset:
  - A 3-cycle low glitch → false start, no byte, no error.
  - Assert `rst` in the middle of DATA → all outputs return to reset values immediately. A following frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_rx_axis.sv
// rtl/uart_rx_axis.sv - 8N1 UART receiver feeding a small byte FIFO with an AXI-Stream style output.
// Bad frames and bytes that arrive while the FIFO is full never reach the stream.
module uart_rx_axis #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_rxd,
  output logic [7:0]                    m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t          state_q;
  logic            rxd_meta_q, rxd_s_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      sh_q;
  logic            frame_err_q, overrun_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [AW:0]     level_q, level_d;

  logic            push_req, pop, full, do_push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  // A good stop bit pushes in the same cycle it is sampled.
  assign push_req = (state_q == S_STOP) && (cnt_q == CNT_FULL) && rxd_s_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      sh_q        <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!rxd_s_q) state_q <= S_START;
        end
        S_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= rxd_s_q ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q <= '0;
            sh_q  <= {rxd_s_q, sh_q[7:1]};
            if (idx_q == 3'd7) state_q <= S_STOP;
            else               idx_q   <= idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q <= '0;
            if (rxd_s_q) begin
              state_q <= S_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (rxd_s_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pop     = m_axis_tvalid && m_axis_tready;
  assign full    = (level_q == LVL_FULL);
  // At full a simultaneous pop frees the head slot, which is also the write slot.
  assign do_push = push_req && (!full || pop);

  always_comb begin
    level_d = level_q;
    case ({do_push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= sh_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      overrun_q <= push_req && full && !pop;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign m_axis_tdata  = mem_q[rd_ptr_q];
  assign m_axis_tvalid = (level_q != '0);
  assign fifo_level    = level_q;
  assign frame_err     = frame_err_q;
  assign overrun       = overrun_q;

endmodule
